ob_cmd_deser: RTL and testbench

Byte-stream command deserializer that sits directly upstream of the order-book core. It assembles fixed-length command frames from an 8-bit ready/valid link into a packed `ob_pkg::cmd_t` and drives the core's `cmd_vld_r`/`cmd_r` inputs. It holds each completed command until the core's `cmd_full_r` is low. Malformed frames are dropped and counted.

---
 rtl/ob_pkg.sv | 59 +++++
 rtl/ob_sat_cnt.sv | 33 +++
 rtl/ob_cmd_deser.sv | 170 +++++++++++++++++
 tb/tb_ob_cmd_deser.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// Shared order-book types: opcodes, the packed command word and the wire header.
// No logic here, so there is no latency and no backpressure.
// The deserializer uses the header struct and the two helper functions below.
package ob_pkg;

    localparam int OPCODE_W       = 4;
    localparam int FRAME_LEN_BASE = 9;
    localparam int CMD_HDR_RSVD_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        Op_None   = 4'd0,
        Op_Buy    = 4'd1,
        Op_Sell   = 4'd2,
        Op_Cancel = 4'd3
    } opcode_e;

    typedef struct packed {
        logic [15:0] quantity;
        logic [15:0] price;
    } order_t;

    typedef struct packed {
        order_t buy;
        order_t sell;
    } oprand_t;

    typedef struct packed {
        opcode_e     opcode;
        logic [31:0] uid;
        oprand_t     oprand;
    } cmd_t;

    // Wire header byte: reserved nibble on top, opcode below.
    typedef struct packed {
        logic [CMD_HDR_RSVD_W-1:0] rsvd;
        logic [OPCODE_W-1:0]       opcode;
    } cmd_hdr_t;

    // Only buy and sell are carried on this link; every other opcode is malformed.
    function automatic logic hdr_valid(input cmd_hdr_t h);
        return (h.rsvd == '0) && ((h.opcode == Op_Buy) || (h.opcode == Op_Sell));
    endfunction

    // body = {uid, quantity, price}, big-endian as received. The unused side of
    // oprand is left zero so the core sees a clean command.
    function automatic cmd_t build_cmd(input logic [OPCODE_W-1:0] op, input logic [63:0] body);
        cmd_t c;
        c        = '0;
        c.opcode = opcode_e'(op);
        c.uid    = body[63:32];
        if (op == Op_Buy) begin
            c.oprand.buy = body[31:0];
        end else begin
            c.oprand.sell = body[31:0];
        end
        return c;
    endfunction

endpackage

// File: rtl/ob_sat_cnt.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
// Latency: count updates on the clock edge that samples inc.
// Backpressure: none; ports clk, rst (sync active-low), inc, cnt[W-1:0].
module ob_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ob_cmd_deser.sv
// Assembles 9-byte (10 with OB_CMD_DESER_CKSUM_EN: trailing XOR byte) command frames
// from an 8-bit valid/ready link into ob_pkg::cmd_t. Latency: strobe 2 cycles after last byte.
// Backpressure: in_rdy drops while a finished command waits for cmd_full_r to clear.
// Ports: clk, rst (sync active-low), in_vld/in_data/in_rdy byte link, cmd_full_r core
// full flag, cmd_vld_r/cmd_r registered command, err_vld_r drop pulse, err_cnt_r drop count.
module ob_cmd_deser
    import ob_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [7:0]           in_data,
    output logic                 in_rdy,
    input  logic                 cmd_full_r,
    output logic                 cmd_vld_r,
    output cmd_t                 cmd_r,
    output logic                 err_vld_r,
    output logic [ERR_CNT_W-1:0] err_cnt_r
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BODY = 2'd1;
    localparam logic [1:0] DROP = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

`ifdef OB_CMD_DESER_CKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_BASE + 1;
    // The checksum byte arrives after all eight body bytes, so keep all 64 bits.
    localparam int SHREG_W   = 64;
`else
    localparam int FRAME_LEN = FRAME_LEN_BASE;
    // The final body byte is merged straight from in_data, so 7 bytes are stored.
    localparam int SHREG_W   = 56;
`endif

    localparam int               CNT_W    = 4;
    // Counter value while the final byte of the frame is being accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 2);

    logic [1:0]          state_q,   state_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic [OPCODE_W-1:0] op_q,      op_d;
    logic [SHREG_W-1:0]  shreg_q,   shreg_d;
    cmd_t                cmd_q,     cmd_d;
    logic                cmd_vld_q, cmd_vld_d;
    logic                err_vld_q, err_vld_d;
`ifdef OB_CMD_DESER_CKSUM_EN
    logic [7:0]          cksum_q,   cksum_d;
`endif

    logic     accept;
    cmd_hdr_t hdr;

    assign in_rdy = (state_q != HOLD);
    assign accept = in_vld && in_rdy;
    assign hdr    = in_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        shreg_d   = shreg_q;
        cmd_d     = cmd_q;
        cmd_vld_d = 1'b0;
        err_vld_d = 1'b0;
`ifdef OB_CMD_DESER_CKSUM_EN
        cksum_d   = cksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (hdr_valid(hdr)) begin
                        op_d    = hdr.opcode;
                        state_d = BODY;
`ifdef OB_CMD_DESER_CKSUM_EN
                        cksum_d = in_data;
`endif
                    end else begin
                        err_vld_d = 1'b1;
                        state_d   = DROP;
                    end
                end
            end
            BODY: begin
                if (accept) begin
                    cnt_d = cnt_q + 4'd1;
`ifdef OB_CMD_DESER_CKSUM_EN
                    cksum_d = cksum_q ^ in_data;
                    if (cnt_q != LAST_CNT) begin
                        shreg_d = {shreg_q[SHREG_W-9:0], in_data};
                    end else if (cksum_q == in_data) begin
                        // Running XOR of bytes 0..8 equals the trailing byte.
                        cmd_d   = build_cmd(op_q, shreg_q);
                        state_d = HOLD;
                    end else begin
                        err_vld_d = 1'b1;
                        state_d   = IDLE;
                    end
`else
                    shreg_d = {shreg_q[SHREG_W-9:0], in_data};
                    if (cnt_q == LAST_CNT) begin
                        cmd_d   = build_cmd(op_q, {shreg_q, in_data});
                        state_d = HOLD;
                    end
`endif
                end
            end
            DROP: begin
                if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                // HOLD: the core's full flag lags by a cycle, which is safe because
                // a new command cannot complete sooner than a whole frame later.
                if (!cmd_full_r) begin
                    cmd_vld_d = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            shreg_q   <= '0;
            cmd_q     <= '0;
            cmd_vld_q <= 1'b0;
            err_vld_q <= 1'b0;
`ifdef OB_CMD_DESER_CKSUM_EN
            cksum_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            shreg_q   <= shreg_d;
            cmd_q     <= cmd_d;
            cmd_vld_q <= cmd_vld_d;
            err_vld_q <= err_vld_d;
`ifdef OB_CMD_DESER_CKSUM_EN
            cksum_q   <= cksum_d;
`endif
        end
    end

    // Counter advances on the same edge that raises err_vld_r.
    ob_sat_cnt #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_vld_d),
        .cnt (err_cnt_r)
    );

    assign cmd_vld_r = cmd_vld_q;
    assign cmd_r     = cmd_q;
    assign err_vld_r = err_vld_q;

endmodule

// File: tb/tb_ob_cmd_deser.sv
module tb_ob_cmd_deser;
    import ob_pkg::*;

`ifdef OB_CMD_DESER_CKSUM_EN
    localparam int FRAME_LEN = 10;
`else
    localparam int FRAME_LEN = 9;
`endif

    typedef logic [7:0] frame_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_rdy;
    logic        cmd_full_r = 1'b0;
    logic        cmd_vld_r;
    cmd_t        cmd_r;
    logic        err_vld_r;
    logic [15:0] err_cnt_r;

    logic        s_in_rdy;
    logic        s_cmd_vld;
    cmd_t        s_cmd;
    logic        s_err_vld;
    logic [1:0]  s_err_cnt;

    always #5 clk = ~clk;

    ob_cmd_deser #(.ERR_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .cmd_full_r(cmd_full_r), .cmd_vld_r(cmd_vld_r), .cmd_r(cmd_r),
        .err_vld_r(err_vld_r), .err_cnt_r(err_cnt_r)
    );

    // Narrow-counter copy sees identical stimulus; exercises saturation.
    ob_cmd_deser #(.ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(s_in_rdy),
        .cmd_full_r(cmd_full_r), .cmd_vld_r(s_cmd_vld), .cmd_r(s_cmd),
        .err_vld_r(s_err_vld), .err_cnt_r(s_err_cnt)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc = 0;
    bit chk_on = 1'b0;
    bit rand_full = 1'b0;
    int n_strobe = 0;
    int n_errp = 0;
    int strobe_cyc = -1;
    int acc_cyc = -1;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: frames as byte lists ----------------
    frame_t m_frame;
    bit     m_hold = 0;
    bit     m_vld = 0;
    bit     m_err = 0;
    bit     m_drop = 0;
    int     m_errs = 0;
    cmd_t   m_cmd = '0;

    function automatic cmd_t decode(input frame_t f);
        cmd_t c;
        c        = '0;
        c.opcode = opcode_e'(f[0][3:0]);
        c.uid    = {f[1], f[2], f[3], f[4]};
        if (f[0][3:0] == 4'd1) begin
            c.oprand.buy.quantity = {f[5], f[6]};
            c.oprand.buy.price    = {f[7], f[8]};
        end else begin
            c.oprand.sell.quantity = {f[5], f[6]};
            c.oprand.sell.price    = {f[7], f[8]};
        end
        return c;
    endfunction

    always @(posedge clk) begin
        logic [7:0] x;
        if (!rst) begin
            m_frame.delete();
            m_hold = 0; m_vld = 0; m_err = 0; m_drop = 0; m_errs = 0; m_cmd = '0;
        end else begin
            m_vld = 0;
            m_err = 0;
            if (m_hold) begin
                if (!cmd_full_r) begin
                    m_vld  = 1;
                    m_hold = 0;
                end
            end else if (in_vld) begin
                m_frame.push_back(in_data);
                if (m_frame.size() == 1) begin
                    m_drop = !((in_data[7:4] == 4'd0) && (in_data[3:0] == 4'd1 || in_data[3:0] == 4'd2));
                    if (m_drop) begin
                        m_err = 1;
                        m_errs++;
                    end
                end
                if (m_frame.size() == FRAME_LEN) begin
                    if (!m_drop) begin
                        x = 8'h00;
                        for (int i = 0; i < 9; i++) x = x ^ m_frame[i];
                        if ((FRAME_LEN == 9) || (x == m_frame[FRAME_LEN-1])) begin
                            m_hold = 1;
                            m_cmd  = decode(m_frame);
                        end else begin
                            m_err = 1;
                            m_errs++;
                        end
                    end
                    m_frame.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_rdy", in_rdy, !m_hold);
            chk("cmd_vld_r", cmd_vld_r, m_vld);
            chk("cmd_r", cmd_r, m_cmd);
            chk("err_vld_r", err_vld_r, m_err);
            chk("err_cnt_r", err_cnt_r, (m_errs > 65535) ? 65535 : m_errs);
            chk("sat_in_rdy", s_in_rdy, !m_hold);
            chk("sat_cmd_vld", s_cmd_vld, m_vld);
            chk("sat_cmd", s_cmd, m_cmd);
            chk("sat_err_vld", s_err_vld, m_err);
            chk("sat_err_cnt", s_err_cnt, (m_errs > 3) ? 3 : m_errs);
            if (cmd_vld_r) begin
                n_strobe++;
                strobe_cyc = cyc;
            end
            if (err_vld_r) n_errp++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_full) cmd_full_r = ($urandom_range(0, 2) == 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard   = 0;
        in_vld  = 1'b1;
        in_data = b;
        forever begin
            @(negedge clk);
            if (in_rdy) begin
                acc_cyc = cyc;
                break;
            end
            guard++;
            if (guard > 300) begin
                n_vec++;
                n_mis++;
                $display("FAIL send_byte_timeout: in_rdy stuck at %b, required 1", in_rdy);
                break;
            end
            tick();
        end
        tick();
        in_vld = 1'b0;
    endtask

    task automatic send_frame(input frame_t f, input int gap_max, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            send_byte(f[i]);
        end
    endtask

    function automatic frame_t mk_frame(input logic [7:0] hdr, input logic [31:0] uid,
                                        input logic [15:0] qty, input logic [15:0] prc,
                                        input bit flip);
        frame_t f;
        logic [7:0] x;
        f = {hdr, uid[31:24], uid[23:16], uid[15:8], uid[7:0],
             qty[15:8], qty[7:0], prc[15:8], prc[7:0]};
        x = 8'h00;
        foreach (f[i]) x = x ^ f[i];
        if (FRAME_LEN == 10) f.push_back(flip ? (x ^ 8'h04) : x);
        return f;
    endfunction

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        frame_t f;
        int s0, e0, bad;
        logic [7:0] h;

        rst = 1'b0;
        tick();
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_in_rdy", in_rdy, 1'b1);
        chk("reset_cmd_vld", cmd_vld_r, 1'b0);
        chk("reset_err_cnt", err_cnt_r, 16'd0);
        chk("reset_cmd", cmd_r, 100'd0);
        tick();
        rst = 1'b1;
        tick();

        // Buy frame, no gaps, latency pinned by hand.
        s0 = n_strobe;
        f = mk_frame(8'h01, 32'hDEADBEEF, 16'h0064, 16'h1388, 1'b0);
        send_frame(f, 0, FRAME_LEN);
        idle(4);
        chk("buy_strobes", n_strobe - s0, 1);
        chk("buy_latency", strobe_cyc - acc_cyc, 2);
        chk("buy_opcode", cmd_r.opcode, 4'd1);
        chk("buy_uid", cmd_r.uid, 32'hDEADBEEF);
        chk("buy_qty", cmd_r.oprand.buy.quantity, 16'h0064);
        chk("buy_price", cmd_r.oprand.buy.price, 16'h1388);
        chk("buy_sell_side_zero", cmd_r.oprand.sell, 32'h0);
        chk("buy_err_cnt", err_cnt_r, 16'd0);

        // Sell frame with random bubbles.
        s0 = n_strobe;
        f = mk_frame(8'h02, 32'h12345678, 16'h00C8, 16'h0FA0, 1'b0);
        send_frame(f, 3, FRAME_LEN);
        idle(5);
        chk("sell_strobes", n_strobe - s0, 1);
        chk("sell_uid", cmd_r.uid, 32'h12345678);
        chk("sell_qty", cmd_r.oprand.sell.quantity, 16'h00C8);
        chk("sell_price", cmd_r.oprand.sell.price, 16'h0FA0);

        // Core full for 20 cycles after the last byte.
        s0 = n_strobe;
        cmd_full_r = 1'b1;
        f = mk_frame(8'h01, 32'hCAFEF00D, 16'h0001, 16'h0002, 1'b0);
        send_frame(f, 0, FRAME_LEN);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_rdy !== 1'b0) bad++;
            tick();
        end
        chk("full_in_rdy_high_cycles", bad, 0);
        chk("full_no_strobe", n_strobe - s0, 0);
        chk("full_cmd_stable", cmd_r.uid, 32'hCAFEF00D);
        cmd_full_r = 1'b0;
        tick();
        @(negedge clk);
        chk("release_strobe", cmd_vld_r, 1'b1);
        chk("release_in_rdy", in_rdy, 1'b1);
        tick();

        // Malformed headers: reserved bits, undefined opcode.
        s0 = n_strobe;
        e0 = n_errp;
        f = mk_frame(8'h1F, 32'h11111111, 16'h2222, 16'h3333, 1'b0);
        send_frame(f, 0, FRAME_LEN);
        f = mk_frame(8'h05, 32'h44444444, 16'h5555, 16'h6666, 1'b0);
        send_frame(f, 1, FRAME_LEN);
        idle(3);
        chk("bad_hdr_err_pulses", n_errp - e0, 2);
        chk("bad_hdr_err_cnt", err_cnt_r, 16'd2);
        chk("bad_hdr_no_strobe", n_strobe - s0, 0);
        chk("bad_hdr_in_rdy", in_rdy, 1'b1);

        // Reset after byte 5 of a buy frame.
        s0 = n_strobe;
        f = mk_frame(8'h01, 32'hA5A5A5A5, 16'h0101, 16'h0202, 1'b0);
        send_frame(f, 0, 6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_err_cnt", err_cnt_r, 16'd0);
        chk("rst_mid_cmd", cmd_r, 100'd0);
        chk("rst_mid_in_rdy", in_rdy, 1'b1);
        tick();
        idle(5);
        chk("rst_mid_no_strobe", n_strobe - s0, 0);
        f = mk_frame(8'h02, 32'h0BADCAFE, 16'h0007, 16'h0009, 1'b0);
        send_frame(f, 0, FRAME_LEN);
        idle(3);
        chk("post_rst_strobe", n_strobe - s0, 1);
        chk("post_rst_uid", cmd_r.uid, 32'h0BADCAFE);
        chk("post_rst_sell_qty", cmd_r.oprand.sell.quantity, 16'h0007);

`ifdef OB_CMD_DESER_CKSUM_EN
        s0 = n_strobe;
        e0 = n_errp;
        f = mk_frame(8'h01, 32'h01020304, 16'h0506, 16'h0708, 1'b0);
        send_frame(f, 0, FRAME_LEN);
        idle(3);
        chk("cksum_ok_strobe", n_strobe - s0, 1);
        chk("cksum_ok_uid", cmd_r.uid, 32'h01020304);
        f = mk_frame(8'h01, 32'h0A0B0C0D, 16'h0506, 16'h0708, 1'b1);
        send_frame(f, 0, FRAME_LEN);
        idle(3);
        chk("cksum_bad_no_strobe", n_strobe - s0, 1);
        chk("cksum_bad_err_pulse", n_errp - e0, 1);
        chk("cksum_bad_cmd_kept", cmd_r.uid, 32'h01020304);
`endif

        // Randomized traffic with a toggling full flag.
        rand_full = 1'b1;
        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 4))
                0, 1: h = 8'h01;
                2, 3: h = 8'h02;
                default: begin
                    h = 8'($urandom_range(0, 255));
                    if (h == 8'h01 || h == 8'h02) h = 8'h13;
                end
            endcase
            f = mk_frame(h, $urandom, 16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0));
            send_frame(f, $urandom_range(0, 2), FRAME_LEN);
        end
        rand_full = 1'b0;
        cmd_full_r = 1'b0;
        idle(6);

        // Saturation of the 2-bit counter after a fresh reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            f = mk_frame(8'hF0 | 8'(k), 32'h0, 16'h0, 16'h0, 1'b0);
            send_frame(f, 0, FRAME_LEN);
        end
        idle(3);
        chk("sat_cnt_final", s_err_cnt, 2'd3);
        chk("wide_cnt_final", err_cnt_r, 16'd5);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
